// File: rtl/key_entry_ctrl.sv
// Keypad entry sequencer: builds a BCD entry from scanner key strobes, hands it
// off over valid/ready, and discards entries abandoned for TIMEOUT_MS.
module key_entry_ctrl #(
    parameter int DIGITS     = 4,
    parameter int T1MS       = 50_000,
    parameter int TIMEOUT_MS = 5000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            key_data,
    input  logic                  key_flag,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [3:0]            out_len,
    output logic [4*DIGITS-1:0]   disp_bcd,
    output logic [3:0]            disp_len,
    output logic                  busy,
    output logic                  err
);
    localparam int W  = 4*DIGITS;
    localparam int PW = (T1MS > 1) ? $clog2(T1MS) : 1;
    localparam int MW = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(T1MS - 1);
    localparam logic [MW-1:0] MS_MAX    = MW'(TIMEOUT_MS - 1);
    localparam logic [3:0]    DIG_L     = 4'(DIGITS);

    typedef enum logic [1:0] {IDLE, ENTRY, HOLD} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [MW-1:0] ms_cnt;
    logic          tick;

    assign tick = (presc == PRESC_MAX);
    assign busy = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            presc     <= '0;
            ms_cnt    <= '0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_len   <= '0;
            disp_bcd  <= '0;
            disp_len  <= '0;
            err       <= 1'b0;
        end else begin
            err   <= 1'b0;
            presc <= tick ? '0 : presc + 1'b1;
            // Idle time only accumulates while a partial entry is on display
            if (key_flag || state != ENTRY)
                ms_cnt <= '0;
            else if (tick)
                ms_cnt <= ms_cnt + 1'b1;

            case (state)
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                    if (key_flag)
                        err <= 1'b1;
                end
                default: begin
                    if (key_flag) begin
                        if (key_data <= 4'd9) begin
                            if (disp_len < DIG_L) begin
                                disp_bcd <= (disp_bcd << 4) | W'(key_data);
                                disp_len <= disp_len + 1'b1;
                                state    <= ENTRY;
                            end else begin
                                err <= 1'b1;
                            end
                        end else begin
                            case (key_data)
                                4'hA: begin
                                    if (disp_len != 4'd0) begin
                                        out_bcd   <= disp_bcd;
                                        out_len   <= disp_len;
                                        out_valid <= 1'b1;
                                        disp_bcd  <= '0;
                                        disp_len  <= '0;
                                        state     <= HOLD;
                                    end else begin
                                        err <= 1'b1;
                                    end
                                end
                                4'hB: begin
                                    if (disp_len != 4'd0) begin
                                        disp_bcd <= disp_bcd >> 4;
                                        disp_len <= disp_len - 1'b1;
                                        state    <= (disp_len == 4'd1) ? IDLE : ENTRY;
                                    end else begin
                                        err <= 1'b1;
                                    end
                                end
                                4'hC: begin
                                    disp_bcd <= '0;
                                    disp_len <= '0;
                                    state    <= IDLE;
                                end
                                default: ;
                            endcase
                        end
                    end else if (state == ENTRY && tick && ms_cnt == MS_MAX) begin
                        disp_bcd <= '0;
                        disp_len <= '0;
                        ms_cnt   <= '0;
                        state    <= IDLE;
                        err      <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_key_entry_ctrl.sv
// Bench for key_entry_ctrl: vector table, directed corner sequences and random
// keys, all checked cycle by cycle against a queue-based model.
module tb_key_entry_ctrl;
    localparam int DIGITS = 4;
    localparam int T1MS   = 10;
    localparam int TO     = 3;
    localparam int W      = 4*DIGITS;

    logic           clk = 1'b0;
    logic           rst, key_flag, out_ready;
    logic [3:0]     key_data;
    logic           out_valid, busy, err;
    logic [W-1:0]   out_bcd, disp_bcd;
    logic [3:0]     out_len, disp_len;

    key_entry_ctrl #(.DIGITS(DIGITS), .T1MS(T1MS), .TIMEOUT_MS(TO)) dut (
        .clk(clk), .rst(rst), .key_data(key_data), .key_flag(key_flag),
        .out_ready(out_ready), .out_valid(out_valid), .out_bcd(out_bcd),
        .out_len(out_len), .disp_bcd(disp_bcd), .disp_len(disp_len),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: the entry is a list of digits, oldest first
    int           q[$];
    bit           m_hold, m_err;
    logic [W-1:0] m_obcd;
    int           m_olen;
    int           pc, ticks;

    function automatic logic [W-1:0] pack(input int d[$]);
        logic [W-1:0] v = '0;
        foreach (d[i]) v = (v << 4) | W'(d[i]);
        return v;
    endfunction

    task automatic model_update(input bit r, input bit kf, input int kd, input bit rdy);
        bit tk;
        if (r) begin
            q.delete(); m_hold = 0; m_err = 0; m_obcd = '0; m_olen = 0; pc = 0; ticks = 0;
            return;
        end
        tk = (pc == T1MS - 1);
        pc = (pc + 1) % T1MS;
        m_err = 0;
        if (m_hold) begin
            if (rdy) m_hold = 0;
            if (kf) m_err = 1;
            ticks = 0;
        end else if (kf) begin
            ticks = 0;
            if (kd <= 9) begin
                if (q.size() < DIGITS) q.push_back(kd); else m_err = 1;
            end else if (kd == 10) begin
                if (q.size() > 0) begin
                    m_obcd = pack(q); m_olen = q.size(); m_hold = 1; q.delete();
                end else m_err = 1;
            end else if (kd == 11) begin
                if (q.size() > 0) void'(q.pop_back()); else m_err = 1;
            end else if (kd == 12) begin
                q.delete();
            end
        end else if (q.size() == 0) begin
            ticks = 0;
        end else if (tk) begin
            ticks++;
            if (ticks == TO) begin
                q.delete(); m_err = 1; ticks = 0;
            end
        end
    endtask

    task automatic tchk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit kf, input logic [3:0] kd, input bit rdy);
        logic [63:0] act, exp;
        rst = r; key_flag = kf; key_data = kd; out_ready = rdy;
        @(posedge clk);
        model_update(r, kf, int'(kd), rdy);
        #1;
        act = 64'({disp_bcd, disp_len, out_valid, out_bcd, out_len, busy, err});
        exp = 64'({pack(q), 4'(q.size()), m_hold, m_obcd, 4'(m_olen), m_hold, m_err});
        tchk("model", act, exp);
    endtask

    typedef struct {
        bit          kf;
        logic [3:0]  kd;
        bit          rdy;
        logic [15:0] dbcd;
        logic [3:0]  dlen;
        bit          ov;
        logic [15:0] obcd;
        logic [3:0]  olen;
        bit          er;
    } vec_t;

    vec_t tbl[$];
    bit   seen;
    bit   found;

    initial begin
        rst = 1'b1; key_flag = 1'b0; key_data = 4'h0; out_ready = 1'b0;
        #1;
        step(1, 0, 4'h0, 0);
        step(1, 0, 4'h0, 0);
        tchk("reset_state", 64'({out_valid, out_bcd, out_len, disp_bcd, disp_len, busy, err}), 64'd0);

        tbl.push_back('{1'b1, 4'h1, 1'b1, 16'h0001, 4'd1, 1'b0, 16'h0000, 4'd0, 1'b0});
        tbl.push_back('{1'b1, 4'h2, 1'b1, 16'h0012, 4'd2, 1'b0, 16'h0000, 4'd0, 1'b0});
        tbl.push_back('{1'b1, 4'h3, 1'b1, 16'h0123, 4'd3, 1'b0, 16'h0000, 4'd0, 1'b0});
        tbl.push_back('{1'b1, 4'hA, 1'b1, 16'h0000, 4'd0, 1'b1, 16'h0123, 4'd3, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 16'h0000, 4'd0, 1'b0, 16'h0123, 4'd3, 1'b0});
        tbl.push_back('{1'b1, 4'hA, 1'b1, 16'h0000, 4'd0, 1'b0, 16'h0123, 4'd3, 1'b1});
        tbl.push_back('{1'b1, 4'hB, 1'b1, 16'h0000, 4'd0, 1'b0, 16'h0123, 4'd3, 1'b1});
        tbl.push_back('{1'b1, 4'hC, 1'b1, 16'h0000, 4'd0, 1'b0, 16'h0123, 4'd3, 1'b0});
        tbl.push_back('{1'b1, 4'hF, 1'b1, 16'h0000, 4'd0, 1'b0, 16'h0123, 4'd3, 1'b0});
        tbl.push_back('{1'b1, 4'h1, 1'b0, 16'h0001, 4'd1, 1'b0, 16'h0123, 4'd3, 1'b0});
        tbl.push_back('{1'b1, 4'h2, 1'b0, 16'h0012, 4'd2, 1'b0, 16'h0123, 4'd3, 1'b0});
        tbl.push_back('{1'b1, 4'h3, 1'b0, 16'h0123, 4'd3, 1'b0, 16'h0123, 4'd3, 1'b0});
        tbl.push_back('{1'b1, 4'h4, 1'b0, 16'h1234, 4'd4, 1'b0, 16'h0123, 4'd3, 1'b0});
        tbl.push_back('{1'b1, 4'h5, 1'b0, 16'h1234, 4'd4, 1'b0, 16'h0123, 4'd3, 1'b1});
        tbl.push_back('{1'b1, 4'hE, 1'b0, 16'h1234, 4'd4, 1'b0, 16'h0123, 4'd3, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 16'h1234, 4'd4, 1'b0, 16'h0123, 4'd3, 1'b0});
        tbl.push_back('{1'b1, 4'hC, 1'b0, 16'h0000, 4'd0, 1'b0, 16'h0123, 4'd3, 1'b0});

        foreach (tbl[i]) begin
            step(0, tbl[i].kf, tbl[i].kd, tbl[i].rdy);
            tchk($sformatf("vec%0d", i),
                 64'({disp_bcd, disp_len, out_valid, out_bcd, out_len, busy, err}),
                 64'({tbl[i].dbcd, tbl[i].dlen, tbl[i].ov, tbl[i].obcd, tbl[i].olen, tbl[i].ov, tbl[i].er}));
        end

        // Backspace inside an entry, then a long stall on out_ready
        step(0, 1, 4'h7, 0);
        step(0, 1, 4'h8, 0);
        step(0, 1, 4'hB, 0);
        step(0, 1, 4'h9, 0);
        step(0, 1, 4'hA, 0);
        tchk("hold_bcd", 64'({out_bcd, out_len}), 64'({16'h0079, 4'd2}));
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 4'h0, 0);
            tchk("hold_valid", 64'({out_valid, busy, out_bcd}), 64'({1'b1, 1'b1, 16'h0079}));
        end
        step(0, 1, 4'h5, 0);
        tchk("hold_key", 64'({err, disp_len, out_valid}), 64'({1'b1, 4'd0, 1'b1}));
        step(0, 0, 4'h0, 1);
        tchk("hold_release", 64'({out_valid, busy, out_bcd, out_len}), 64'({1'b0, 1'b0, 16'h0079, 4'd2}));

        // Timeout discards an abandoned entry
        step(0, 1, 4'h6, 1);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(0, 0, 4'h0, 1);
            if (err) seen = 1;
        end
        tchk("timeout_err", 64'({seen, disp_len, disp_bcd}), 64'({1'b1, 4'd0, 16'h0000}));

        // Key on exactly the expiry tick wins over the timeout
        step(0, 1, 4'h6, 1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (q.size() > 0 && ticks == TO - 1 && pc == T1MS - 1) found = 1;
            else step(0, 0, 4'h0, 1);
        end
        tchk("expiry_found", 64'(found), 64'd1);
        step(0, 1, 4'h4, 1);
        tchk("expiry_key", 64'({disp_bcd, disp_len, err}), 64'({16'h0064, 4'd2, 1'b0}));

        // Reset in the middle of a stalled handshake
        step(0, 1, 4'hC, 0);
        step(0, 1, 4'h2, 0);
        step(0, 1, 4'hA, 0);
        step(0, 0, 4'h0, 0);
        step(1, 0, 4'h0, 0);
        tchk("reset_hold", 64'({out_valid, disp_len, out_bcd, busy}), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(499, 0) == 0),
                 ($urandom_range(7, 0) < 2),
                 4'($urandom_range(15, 0)),
                 ($urandom_range(3, 0) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
